bfp_scale_ctrl: RTL and testbench

//  Block-floating-point scale controller for the pipelined FFT.
//  - Monitors valid samples leaving one FFT stage and tracks the minimum headroom over each 2^LGN-sample frame.
//  - At frame end, issues the shift amount the next stage's rounding datapath applies, and accumulates a per-frame exponent.
//  - Sits beside the stage's round instance and configures its right-shift once per frame.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/hdr_detect.sv | 32 +++
 rtl/bfp_scale_ctrl.sv | 177 +++++++++++++++++
 tb/tb_bfp_scale_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the pipelined FFT block-floating-point logic.
//   DEFAULT_DATA_W : default signed sample width seen between FFT stages
//   bfp_state_e    : ACC / UPDATE encodings of the scale-controller FSM
//   clog2()        : ceiling log2 usable in parameter expressions
package fft_pkg;

  localparam int DEFAULT_DATA_W = 16;

  typedef enum logic {
    ST_ACC    = 1'b0,
    ST_UPDATE = 1'b1
  } bfp_state_e;

  // clog2(1) = 0, clog2(2) = 1, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hdr_detect.sv
// Combinational headroom detector for one signed sample.
// Headroom is the count of leading bits equal to the sign bit, minus one
// (the sign bit itself), so it ranges 0..DATA_W-1.
//   i_data : signed sample (DATA_W bits)
//   o_hr   : headroom in bits (HR_W bits)
module hdr_detect
  import fft_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int HR_W   = clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [HR_W-1:0]   o_hr
);

  logic run_c;

  // Walk down from just below the sign bit; stop at the first bit that
  // differs from the sign.
  always_comb begin
    o_hr  = '0;
    run_c = 1'b1;
    for (int i = DATA_W - 2; i >= 0; i--) begin
      if (run_c && (i_data[i] == i_data[DATA_W-1])) begin
        o_hr = o_hr + HR_W'(1);
      end else begin
        run_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bfp_scale_ctrl.sv
// Block-floating-point scale controller for one pipelined FFT stage.
// Tracks the minimum headroom of valid samples over each 2^LGN-sample
// frame and, once per frame, issues the right-shift the next stage's
// rounding datapath must apply, accumulating a saturating exponent.
//
// Ports:
//   mclk        : clock
//   i_init      : synchronous active-high reset; wins over a same-cycle i_vld
//   i_vld       : sample valid; every high cycle is one accepted sample (no
//                 back-pressure exists, so nothing is ever stalled or lost)
//   i_data      : signed sample
//   o_shift     : shift for the next frame, held between updates
//   o_shift_vld : one-cycle pulse when o_shift / o_exp update
//   o_exp       : cumulative shift since init, saturating at 2^EXP_W-1
//   o_clip_cnt  : frames whose shift was clamped to MAX_SHIFT, saturating
//                 (present only when BFP_SCALE_CTRL_STATS_EN is defined)
//
// Timing: the edge accepting a frame's last sample moves the FSM to UPDATE;
// UPDATE latches the requested shift; the following edge applies it, so
// o_shift_vld is high after the second edge following the last sample.
module bfp_scale_ctrl
  import fft_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int LGN       = 10,
  parameter int GUARD     = 1,
  parameter int MAX_SHIFT = 3,
  parameter int EXP_W     = 8,
  parameter int SHIFT_W   = clog2(MAX_SHIFT + 1)
) (
  input  logic               mclk,
  input  logic               i_init,
  input  logic               i_vld,
  input  logic [DATA_W-1:0]  i_data,
  output logic [SHIFT_W-1:0] o_shift,
  output logic               o_shift_vld,
  output logic [EXP_W-1:0]   o_exp
`ifdef BFP_SCALE_CTRL_STATS_EN
  ,
  output logic [15:0]        o_clip_cnt
`endif
);

  localparam int HR_W  = clog2(DATA_W);
  localparam int REQ_W = (clog2(GUARD + 1) > 1) ? clog2(GUARD + 1) : 1;
  localparam int SUM_W = ((EXP_W > SHIFT_W) ? EXP_W : SHIFT_W) + 1;

  bfp_state_e         state_q, state_d;
  logic [LGN-1:0]     cnt_q, cnt_d;
  logic [HR_W-1:0]    min_hr_q, min_hr_d;
  logic               pend_q, pend_d;
  logic [REQ_W-1:0]   req_q, req_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               shift_vld_q, shift_vld_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [HR_W-1:0]    hr_c;
  logic [SHIFT_W-1:0] shift_new_c;
  logic [SUM_W-1:0]   exp_sum_c;
`ifdef BFP_SCALE_CTRL_STATS_EN
  logic [15:0]        clip_cnt_q, clip_cnt_d;
`endif

  hdr_detect #(
    .DATA_W (DATA_W),
    .HR_W   (HR_W)
  ) u_hdr_detect (
    .i_data (i_data),
    .o_hr   (hr_c)
  );

  // Clamp the latched request and form the unsaturated exponent sum.
  always_comb begin
    shift_new_c = (int'(req_q) > MAX_SHIFT) ? SHIFT_W'(MAX_SHIFT) : SHIFT_W'(req_q);
    exp_sum_c   = SUM_W'(exp_q) + SUM_W'(shift_new_c);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    min_hr_d    = min_hr_q;
    pend_d      = 1'b0;
    req_d       = req_q;
    shift_d     = shift_q;
    shift_vld_d = 1'b0;
    exp_d       = exp_q;
`ifdef BFP_SCALE_CTRL_STATS_EN
    clip_cnt_d  = clip_cnt_q;
`endif

    // Second stage of the update: publish the shift and the exponent.
    if (pend_q) begin
      shift_d     = shift_new_c;
      shift_vld_d = 1'b1;
      if (exp_sum_c > SUM_W'({EXP_W{1'b1}})) begin
        exp_d = '1;
      end else begin
        exp_d = EXP_W'(exp_sum_c);
      end
`ifdef BFP_SCALE_CTRL_STATS_EN
      if ((int'(req_q) > MAX_SHIFT) && (clip_cnt_q != 16'hFFFF)) begin
        clip_cnt_d = clip_cnt_q + 16'd1;
      end
`endif
    end

    case (state_q)
      ST_ACC: begin
        if (i_vld) begin
          cnt_d = cnt_q + LGN'(1);
          if (hr_c < min_hr_q) begin
            min_hr_d = hr_c;
          end
          // Last sample of the frame: the counter wraps to zero here.
          if (cnt_q == '1) begin
            state_d = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: begin
        state_d = ST_ACC;
        pend_d  = 1'b1;
        if (int'(min_hr_q) < GUARD) begin
          req_d = REQ_W'(GUARD - int'(min_hr_q));
        end else begin
          req_d = '0;
        end
        // A sample arriving now opens the next frame.
        if (i_vld) begin
          min_hr_d = hr_c;
          cnt_d    = LGN'(1);
        end else begin
          min_hr_d = HR_W'(DATA_W - 1);
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (i_init) begin
      state_q     <= ST_ACC;
      cnt_q       <= '0;
      min_hr_q    <= HR_W'(DATA_W - 1);
      pend_q      <= 1'b0;
      req_q       <= '0;
      shift_q     <= '0;
      shift_vld_q <= 1'b0;
      exp_q       <= '0;
`ifdef BFP_SCALE_CTRL_STATS_EN
      clip_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      min_hr_q    <= min_hr_d;
      pend_q      <= pend_d;
      req_q       <= req_d;
      shift_q     <= shift_d;
      shift_vld_q <= shift_vld_d;
      exp_q       <= exp_d;
`ifdef BFP_SCALE_CTRL_STATS_EN
      clip_cnt_q  <= clip_cnt_d;
`endif
    end
  end

  assign o_shift     = shift_q;
  assign o_shift_vld = shift_vld_q;
  assign o_exp       = exp_q;
`ifdef BFP_SCALE_CTRL_STATS_EN
  assign o_clip_cnt  = clip_cnt_q;
`endif

endmodule

// File: tb/tb_bfp_scale_ctrl.sv
// Bench for bfp_scale_ctrl. Two instances share one stimulus stream:
//   A: LGN=3, GUARD=1, MAX_SHIFT=3, EXP_W=8
//   B: LGN=3, GUARD=5, MAX_SHIFT=3, EXP_W=2  (clamping and exponent saturation)
// A frame-level model predicts every output after every edge; directed
// sequences add literal expectations at key points.
module tb_bfp_scale_ctrl;

  localparam int DATA_W    = 16;
  localparam int LGN       = 3;
  localparam int N         = 8;
  localparam int MAX_SHIFT = 3;

  logic        mclk = 1'b0;
  logic        i_init;
  logic        i_vld;
  logic [15:0] i_data;
  logic [1:0]  shift_a, shift_b;
  logic        vld_a, vld_b;
  logic [7:0]  exp_a;
  logic [1:0]  exp_b;
`ifdef BFP_SCALE_CTRL_STATS_EN
  logic [15:0] clip_a, clip_b;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulse_a[$];

  // ---------------- clock ----------------
  always #5 mclk = ~mclk;

  // ---------------- DUTs ----------------
  bfp_scale_ctrl #(
    .DATA_W(DATA_W), .LGN(LGN), .GUARD(1), .MAX_SHIFT(MAX_SHIFT), .EXP_W(8)
  ) u_dut_a (
    .mclk        (mclk),
    .i_init      (i_init),
    .i_vld       (i_vld),
    .i_data      (i_data),
    .o_shift     (shift_a),
    .o_shift_vld (vld_a),
    .o_exp       (exp_a)
`ifdef BFP_SCALE_CTRL_STATS_EN
    ,
    .o_clip_cnt  (clip_a)
`endif
  );

  bfp_scale_ctrl #(
    .DATA_W(DATA_W), .LGN(LGN), .GUARD(5), .MAX_SHIFT(MAX_SHIFT), .EXP_W(2)
  ) u_dut_b (
    .mclk        (mclk),
    .i_init      (i_init),
    .i_vld       (i_vld),
    .i_data      (i_data),
    .o_shift     (shift_b),
    .o_shift_vld (vld_b),
    .o_exp       (exp_b)
`ifdef BFP_SCALE_CTRL_STATS_EN
    ,
    .o_clip_cnt  (clip_b)
`endif
  );

  // ---------------- model ----------------
  int guard_p[2] = '{1, 5};
  int exp_max[2] = '{255, 3};
  int m_cnt[2]   = '{0, 0};
  int m_min[2]   = '{15, 15};
  int m_pend[2]  = '{0, 0};
  int m_due[2]   = '{0, 0};
  int m_req[2]   = '{0, 0};
  int m_shift[2] = '{0, 0};
  int m_exp[2]   = '{0, 0};
  int m_clip[2]  = '{0, 0};
  int m_vld[2]   = '{0, 0};

  // Headroom from magnitude: a value needing L magnitude bits leaves
  // (DATA_W-1-L) redundant sign bits.
  function automatic int hr_of(input logic [15:0] v);
    logic [15:0] m;
    int x;
    int len;
    m   = v[15] ? ~v : v;
    x   = int'(m);
    len = 0;
    while (x > 0) begin
      len = len + 1;
      x   = x >> 1;
    end
    return DATA_W - 1 - len;
  endfunction

  task automatic model_edge(input int i);
    int h;
    int sh;
    if (i_init) begin
      m_cnt[i] = 0; m_min[i] = DATA_W - 1; m_pend[i] = 0;
      m_shift[i] = 0; m_exp[i] = 0; m_clip[i] = 0; m_vld[i] = 0;
    end else begin
      m_vld[i] = 0;
      if (m_pend[i] != 0 && m_due[i] == cyc) begin
        sh = (m_req[i] > MAX_SHIFT) ? MAX_SHIFT : m_req[i];
        if (m_req[i] > MAX_SHIFT && m_clip[i] < 65535) m_clip[i] = m_clip[i] + 1;
        m_shift[i] = sh;
        m_exp[i]   = (m_exp[i] + sh > exp_max[i]) ? exp_max[i] : m_exp[i] + sh;
        m_vld[i]   = 1;
        m_pend[i]  = 0;
      end
      if (i_vld) begin
        h = hr_of(i_data);
        if (h < m_min[i]) m_min[i] = h;
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == N) begin
          m_pend[i] = 1;
          m_due[i]  = cyc + 2;
          m_req[i]  = (m_min[i] < guard_p[i]) ? guard_p[i] - m_min[i] : 0;
          m_cnt[i]  = 0;
          m_min[i]  = DATA_W - 1;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge mclk);
      cyc = cyc + 1;
      model_edge(0);
      model_edge(1);
      #1;
      if (vld_a) pulse_a.push_back(cyc);
      chk("cmp_shift_a", int'(shift_a), m_shift[0]);
      chk("cmp_vld_a",   int'(vld_a),   m_vld[0]);
      chk("cmp_exp_a",   int'(exp_a),   m_exp[0]);
      chk("cmp_shift_b", int'(shift_b), m_shift[1]);
      chk("cmp_vld_b",   int'(vld_b),   m_vld[1]);
      chk("cmp_exp_b",   int'(exp_b),   m_exp[1]);
`ifdef BFP_SCALE_CTRL_STATS_EN
      chk("cmp_clip_a",  int'(clip_a),  m_clip[0]);
      chk("cmp_clip_b",  int'(clip_b),  m_clip[1]);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // One call = one clock edge; returns just after that edge.
  task automatic step(input logic v, input logic [15:0] d, input logic init);
    @(negedge mclk);
    i_vld  = v;
    i_data = d;
    i_init = init;
    @(posedge mclk);
    #1;
  endtask

  task automatic send_const(input int n, input logic [15:0] d);
    for (int k = 0; k < n; k++) step(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 16'h0000, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  logic [15:0] t4[24] = '{
    16'h0000, 16'h8000, 16'h0100, 16'hFFFF, 16'h0010, 16'h0020, 16'h0000, 16'h0400,
    16'h0FFF, 16'h0000, 16'hFFFF, 16'h0100, 16'h0200, 16'h0010, 16'h0000, 16'h0001,
    16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000
  };
  int exp6[4] = '{1, 2, 3, 3};
  int pulse_n;

  initial begin
    i_init = 1'b1;
    i_vld  = 1'b0;
    i_data = 16'h0000;

    // Reset
    step(1'b0, 16'h0000, 1'b1);
    step(1'b1, 16'h7FFF, 1'b1);
    chk("reset_shift_a", int'(shift_a), 0);
    chk("reset_vld_a",   int'(vld_a),   0);
    chk("reset_exp_a",   int'(exp_a),   0);
    chk("reset_exp_b",   int'(exp_b),   0);

    // Frame of 0x0100 (hr 6): no shift, pulse two edges after the 8th sample
    send_const(8, 16'h0100);
    idle(1);
    chk("t1_no_pulse_edge1", int'(vld_a), 0);
    idle(1);
    chk("t1_pulse_edge2", int'(vld_a), 1);
    chk("t1_shift_a",     int'(shift_a), 0);
    chk("t1_exp_a",       int'(exp_a), 0);

    // Zeros plus one 0x7FFF, with gaps
    for (int k = 0; k < 8; k++) begin
      step(1'b1, (k == 3) ? 16'h7FFF : 16'h0000, 1'b0);
      if (k % 2 == 0) idle(1);
    end
    idle(2);
    chk("t2_pulse_a", int'(vld_a), 1);
    chk("t2_shift_a", int'(shift_a), 1);
    chk("t2_exp_a",   int'(exp_a), 1);
    chk("t3_shift_b_clamped", int'(shift_b), 3);
    chk("t3_exp_b",   int'(exp_b), 3);
`ifdef BFP_SCALE_CTRL_STATS_EN
    chk("t3_clip_b",  int'(clip_b), 1);
    chk("t3_clip_a",  int'(clip_a), 0);
`endif
    send_const(8, 16'h0010);
    idle(2);
    chk("t2b_shift_a", int'(shift_a), 0);
    chk("t2b_exp_a",   int'(exp_a), 1);
    chk("t2b_shift_b", int'(shift_b), 0);

    // Three back-to-back frames under continuous valid
    pulse_a.delete();
    for (int k = 0; k < 24; k++) step(1'b1, t4[k], 1'b0);
    idle(3);
    chk("t4_pulse_count", pulse_a.size(), 3);
    if (pulse_a.size() == 3) begin
      chk("t4_spacing_01", pulse_a[1] - pulse_a[0], N);
      chk("t4_spacing_12", pulse_a[2] - pulse_a[1], N);
    end
    chk("t4_exp_a",  int'(exp_a), 2);
    chk("t4_shift_b", int'(shift_b), 0);

    // Init mid-frame with valid high
    send_const(5, 16'h7FFF);
    step(1'b1, 16'h7FFF, 1'b1);
    chk("t5_shift_a", int'(shift_a), 0);
    chk("t5_exp_a",   int'(exp_a), 0);
    chk("t5_vld_a",   int'(vld_a), 0);
    chk("t5_exp_b",   int'(exp_b), 0);
    pulse_n = pulse_a.size();
    send_const(7, 16'h7FFF);
    idle(3);
    chk("t5_no_early_pulse", pulse_a.size(), pulse_n);
    send_const(1, 16'h7FFF);
    idle(1);
    chk("t5_no_pulse_edge1", int'(vld_a), 0);
    idle(1);
    chk("t5_pulse", int'(vld_a), 1);
    chk("t5_shift_after", int'(shift_a), 1);

    // EXP_W=2 saturation on instance B (hr 4 -> shift 1 per frame)
    step(1'b0, 16'h0000, 1'b1);
    for (int f = 0; f < 4; f++) begin
      send_const(8, 16'h0400);
      idle(2);
      chk("t6_vld_b",   int'(vld_b), 1);
      chk("t6_shift_b", int'(shift_b), 1);
      chk("t6_exp_b",   int'(exp_b), exp6[f]);
      chk("t6_shift_a", int'(shift_a), 0);
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
